// File: rtl/cache_refill_ctrl.sv
// Sequencing controller for one cache set: hit handling, dirty write-back and line refill.
// Define CACHE_WRITE_ALLOCATE_EN to refill on store misses instead of writing around the set.
module cache_refill_ctrl #(
  parameter int unsigned TAG_WIDTH    = 20,
  parameter int unsigned OFFSET_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  input  logic                 req_write_i,
  input  logic [31:0]          addr_i,
`ifndef CACHE_WRITE_ALLOCATE_EN
  input  logic [31:0]          write_data_i,
`endif
  output logic                 done_o,
  input  logic                 hit_i,
  input  logic                 dirty_i,
  input  logic [TAG_WIDTH-1:0] tag_dirty_line_i,
  input  logic [31:0]          wb_data_i,
  output logic [5:0]           control_o,
  output logic [31:0]          mem_addr_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_write_data_o,
  input  logic                 mem_ack_i
);

  localparam int unsigned INDEX_WIDTH = 32 - TAG_WIDTH - OFFSET_WIDTH;
  localparam int unsigned CNT_WIDTH   = OFFSET_WIDTH - 2;
  localparam logic [CNT_WIDTH-1:0] CntLast = '1;

  // {write_en, update_en, set_valid, set_dirty, strategy_en, offset_sel}
  localparam logic [5:0] CtrlLoadHit  = 6'b000011;
  localparam logic [5:0] CtrlStoreHit = 6'b111111;
  localparam logic [5:0] CtrlFill     = 6'b100000;
  localparam logic [5:0] CtrlFillLast = 6'b111000;

  typedef enum logic [2:0] {
    StIdle,
    StCompare,
    StWriteback,
    StAllocate,
    StWriteAround
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [TAG_WIDTH-1:0]   victim_tag_q, victim_tag_d;

  logic [TAG_WIDTH-1:0]   req_tag;
  logic [INDEX_WIDTH-1:0] req_index;
  logic                   last_word;
  logic                   unused_addr_bits;

  assign req_tag          = addr_i[31 -: TAG_WIDTH];
  assign req_index        = addr_i[OFFSET_WIDTH +: INDEX_WIDTH];
  assign last_word        = (cnt_q == CntLast);
  assign unused_addr_bits = ^addr_i[OFFSET_WIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      victim_tag_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      victim_tag_q <= victim_tag_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    victim_tag_d = victim_tag_q;
    case (state_q)
      StIdle: begin
        if (req_valid_i) state_d = StCompare;
      end
      StCompare: begin
        cnt_d = '0;
        if (hit_i) begin
          state_d = StIdle;
`ifndef CACHE_WRITE_ALLOCATE_EN
        end else if (req_write_i) begin
          state_d = StWriteAround;
`endif
        end else if (dirty_i) begin
          state_d      = StWriteback;
          victim_tag_d = tag_dirty_line_i;
        end else begin
          state_d = StAllocate;
        end
      end
      StWriteback: begin
        if (mem_ack_i) begin
          cnt_d = cnt_q + 1'b1;
          if (last_word) state_d = StAllocate;
        end
      end
      StAllocate: begin
        // Returning to compare lets the now-valid line serve the request as a hit.
        if (mem_ack_i) begin
          cnt_d = cnt_q + 1'b1;
          if (last_word) state_d = StCompare;
        end
      end
`ifndef CACHE_WRITE_ALLOCATE_EN
      StWriteAround: begin
        if (mem_ack_i) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    done_o           = 1'b0;
    control_o        = '0;
    mem_req_o        = 1'b0;
    mem_we_o         = 1'b0;
    mem_addr_o       = '0;
    mem_write_data_o = '0;
    case (state_q)
      StCompare: begin
        if (hit_i) begin
          done_o    = 1'b1;
          control_o = req_write_i ? CtrlStoreHit : CtrlLoadHit;
        end
      end
      StWriteback: begin
        mem_req_o        = 1'b1;
        mem_we_o         = 1'b1;
        mem_addr_o       = {victim_tag_q, req_index, cnt_q, 2'b00};
        mem_write_data_o = wb_data_i;
      end
      StAllocate: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {req_tag, req_index, cnt_q, 2'b00};
        if (mem_ack_i) control_o = last_word ? CtrlFillLast : CtrlFill;
      end
`ifndef CACHE_WRITE_ALLOCATE_EN
      StWriteAround: begin
        mem_req_o        = 1'b1;
        mem_we_o         = 1'b1;
        mem_addr_o       = {addr_i[31:2], 2'b00};
        mem_write_data_o = write_data_i;
        done_o           = mem_ack_i;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: one-line set model, ack-latency memory responder and a
// transaction-level reference model of hit, write-back, refill and write-around sequences.
module tb_cache_refill_ctrl;

  localparam int TW = 20;
  localparam int OW = 4;
  localparam int IW = 32 - TW - OW;
  localparam int W  = 1 << (OW - 2);
`ifdef CACHE_WRITE_ALLOCATE_EN
  localparam bit WA = 1'b1;
`else
  localparam bit WA = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   write_data = '0;
  logic          done;
  logic          hit;
  logic          dirty;
  logic [TW-1:0] vtag;
  logic [31:0]   wb_data;
  logic [5:0]    control;
  logic [31:0]   mem_addr;
  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic          mem_ack = 1'b0;

  cache_refill_ctrl #(
    .TAG_WIDTH   (TW),
    .OFFSET_WIDTH(OW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_write_i     (req_write),
    .addr_i          (addr),
`ifndef CACHE_WRITE_ALLOCATE_EN
    .write_data_i    (write_data),
`endif
    .done_o          (done),
    .hit_i           (hit),
    .dirty_i         (dirty),
    .tag_dirty_line_i(vtag),
    .wb_data_i       (wb_data),
    .control_o       (control),
    .mem_addr_o      (mem_addr),
    .mem_req_o       (mem_req),
    .mem_we_o        (mem_we),
    .mem_write_data_o(mem_wdata),
    .mem_ack_i       (mem_ack)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic        we;
    logic [31:0] d;
    logic [5:0]  c;
  } txn_t;

  txn_t obs_q[$];
  txn_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Set datapath model: a single line
  bit            line_valid = 1'b0;
  bit            line_dirty = 1'b0;
  logic [TW-1:0] line_tag = '0;
  logic [IW-1:0] line_idx = '0;
  logic [31:0]   line_data [W] = '{default: '0};

  always_comb begin
    hit     = line_valid && (line_tag == addr[31 -: TW]) && (line_idx == addr[OW +: IW]);
    dirty   = line_valid && line_dirty;
    vtag    = line_tag;
    wb_data = line_data[mem_addr[OW-1:2]];
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  // Memory responder: each beat acked after lat_mode idle cycles; also applies set writes
  int lat_mode = 0;
  int wcnt = 0;

  always @(negedge clk) begin
    txn_t t;
    if (mem_req !== 1'b1) begin
      mem_ack = 1'b0;
      wcnt    = lat_mode;
    end else begin
      if (mem_ack) wcnt = lat_mode;
      if (wcnt == 0) mem_ack = 1'b1;
      else begin
        mem_ack = 1'b0;
        wcnt--;
      end
    end
    #1;
    if (mem_ack) begin
      t.a = mem_addr;
      t.we = mem_we;
      t.d = mem_we ? mem_wdata : 32'h0;
      t.c = control;
      obs_q.push_back(t);
    end
    if (control[5] === 1'b1) begin
      if (control[0]) line_data[addr[OW-1:2]] = write_data;
      else            line_data[mem_addr[OW-1:2]] = mem_word(mem_addr);
    end
    if (control[4] === 1'b1) begin
      line_valid = control[3];
      line_dirty = control[2];
      line_tag   = addr[31 -: TW];
      line_idx   = addr[OW +: IW];
    end
  end

  // Reference model: expected memory beats, latency and done-cycle control for one request
  int         exp_lat;
  logic [5:0] exp_ctrl;
  bit         exp_wa;

  task automatic predict(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input int lat);
    txn_t          t;
    logic [TW-1:0] tg;
    logic [IW-1:0] ix;
    tg = a[31 -: TW];
    ix = a[OW +: IW];
    exp_q.delete();
    exp_wa = 1'b0;
    if (line_valid && line_tag == tg && line_idx == ix) begin
      exp_lat  = 1;
      exp_ctrl = wr ? 6'h3F : 6'h03;
    end else if (wr && !WA) begin
      exp_wa = 1'b1;
      t.a = {a[31:2], 2'b00};
      t.we = 1'b1;
      t.d = wd;
      t.c = '0;
      exp_q.push_back(t);
      exp_lat  = 2 + lat;
      exp_ctrl = '0;
    end else begin
      exp_lat = 2;
      if (line_valid && line_dirty) begin
        for (int k = 0; k < W; k++) begin
          t.a = {line_tag, ix, {OW{1'b0}}} + 32'(k * 4);
          t.we = 1'b1;
          t.d = line_data[k];
          t.c = '0;
          exp_q.push_back(t);
          exp_lat += lat + 1;
        end
      end
      for (int k = 0; k < W; k++) begin
        t.a = {tg, ix, {OW{1'b0}}} + 32'(k * 4);
        t.we = 1'b0;
        t.d = '0;
        t.c = (k == W - 1) ? 6'b111000 : 6'b100000;
        exp_q.push_back(t);
        exp_lat += lat + 1;
      end
      exp_ctrl = wr ? 6'h3F : 6'h03;
    end
  endtask

  // Drive one request starting in an idle cycle; returns one cycle after done_o
  int         got_lat;
  logic [5:0] got_ctrl;
  bit         any_ctrl;
  bit         any_req;

  task automatic run_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input int lat);
    obs_q.delete();
    lat_mode = lat;
    got_lat  = -1;
    got_ctrl = 'x;
    any_ctrl = 1'b0;
    any_req  = 1'b0;
    req_valid  = 1'b1;
    req_write  = wr;
    addr       = a;
    write_data = wd;
    for (int c = 0; c < 120 && got_lat < 0; c++) begin
      @(negedge clk);
      #2;
      if (mem_req) any_req = 1'b1;
      if (done) begin
        got_lat  = c;
        got_ctrl = control;
      end else if (control != 6'b0) begin
        any_ctrl = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b want 0", done); end
    n_vec++; if (control !== 6'b0) begin n_err++; $display("FAIL reset control: got %b want 000000", control); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset mem_req: got %b want 0", mem_req); end
    n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset mem_we: got %b want 0", mem_we); end
    n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset mem_addr: got %h want 0", mem_addr); end
    n_vec++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset mem_wdata: got %h want 0", mem_wdata); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    // Start a clean refill and reset it after the third beat has been acked
    obs_q.delete();
    lat_mode  = 0;
    req_valid = 1'b1;
    req_write = 1'b0;
    addr      = 32'h0000_5670;
    for (int c = 0; c < 50 && obs_q.size() < 3; c++) begin
      @(negedge clk);
      #2;
    end
    n_vec++;
    if (obs_q.size() != 3) begin
      n_err++;
      $display("FAIL reset_setup beats: got %0d want 3", obs_q.size());
    end
    rst       = 1'b1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    n_vec++; if (control !== 6'b0) begin n_err++; $display("FAIL midfill_reset control: got %b want 000000", control); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL midfill_reset mem_req: got %b want 0", mem_req); end
    n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL midfill_reset mem_addr: got %h want 0", mem_addr); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL midfill_reset done: got %b want 0", done); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_req(1'b0, 32'h0000_5670, 32'h0, 0);
    n_vec++; if (got_lat != 6) begin n_err++; $display("FAIL restart latency: got %0d want 6", got_lat); end
    n_vec++;
    if (obs_q.size() != 4 || obs_q[0].a !== 32'h0000_5670) begin
      n_err++;
      $display("FAIL restart beats: got %0d beats first %h want 4 beats first 00005670",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].a : 32'hx);
    end
  endtask

  task automatic test_clean_miss();
    logic [5:0] want_c;
    run_req(1'b0, 32'h0000_1234, 32'h0, 0);
    n_vec++; if (got_lat != 6) begin n_err++; $display("FAIL clean_miss latency: got %0d want 6", got_lat); end
    n_vec++; if (got_ctrl !== 6'b000011) begin n_err++; $display("FAIL clean_miss done_ctrl: got %b want 000011", got_ctrl); end
    n_vec++; if (obs_q.size() != 4) begin n_err++; $display("FAIL clean_miss beats: got %0d want 4", obs_q.size()); end
    for (int k = 0; k < 4 && k < obs_q.size(); k++) begin
      want_c = (k == 3) ? 6'b111000 : 6'b100000;
      n_vec++;
      if (obs_q[k].a !== 32'h0000_1230 + 32'(4 * k) || obs_q[k].we !== 1'b0 || obs_q[k].c !== want_c) begin
        n_err++;
        $display("FAIL clean_miss beat%0d: got a=%h we=%b c=%b want a=%h we=0 c=%b", k,
                 obs_q[k].a, obs_q[k].we, obs_q[k].c, 32'h0000_1230 + 32'(4 * k), want_c);
      end
    end
  endtask

  task automatic test_load_hit();
    run_req(1'b0, 32'h0000_1234, 32'h0, 0);
    n_vec++; if (got_lat != 1) begin n_err++; $display("FAIL load_hit latency: got %0d want 1", got_lat); end
    n_vec++; if (got_ctrl !== 6'b000011) begin n_err++; $display("FAIL load_hit control: got %b want 000011", got_ctrl); end
    n_vec++; if (any_req) begin n_err++; $display("FAIL load_hit mem_req: got 1 want 0"); end
  endtask

  task automatic test_store_hit();
    run_req(1'b1, 32'h0000_1238, 32'hDEAD_BEEF, 0);
    n_vec++; if (got_lat != 1) begin n_err++; $display("FAIL store_hit latency: got %0d want 1", got_lat); end
    n_vec++; if (got_ctrl !== 6'b111111) begin n_err++; $display("FAIL store_hit control: got %b want 111111", got_ctrl); end
    n_vec++; if (any_req) begin n_err++; $display("FAIL store_hit mem_req: got 1 want 0"); end
  endtask

  task automatic test_dirty_miss();
    logic [31:0] a_tab [3] = '{32'h0000_3230, 32'h0000_3234, 32'h0000_7230};
    logic        w_tab [3] = '{1'b0, 1'b1, 1'b0};
    int          l_tab [3] = '{0, 0, 2};
    for (int s = 0; s < 3; s++) begin
      predict(w_tab[s], a_tab[s], 32'h0BAD_F00D, l_tab[s]);
      run_req(w_tab[s], a_tab[s], 32'h0BAD_F00D, l_tab[s]);
      n_vec++; if (got_lat != exp_lat) begin n_err++; $display("FAIL dirty_miss%0d latency: got %0d want %0d", s, got_lat, exp_lat); end
      n_vec++; if (got_ctrl !== exp_ctrl) begin n_err++; $display("FAIL dirty_miss%0d done_ctrl: got %b want %b", s, got_ctrl, exp_ctrl); end
      n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL dirty_miss%0d beats: got %0d want %0d", s, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_vec++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL dirty_miss%0d beat%0d: got %h want %h", s, i, obs_q[i], exp_q[i]);
        end
      end
    end
    // Last step: victim tag 3 with word 1 overwritten by the store
    n_vec++; if (got_lat != 26) begin n_err++; $display("FAIL dirty_tag3 latency: got %0d want 26", got_lat); end
    n_vec++;
    if (obs_q.size() < 2 || obs_q[0].a !== 32'h0000_3230 || obs_q[0].d !== mem_word(32'h0000_3230)
        || obs_q[1].d !== 32'h0BAD_F00D) begin
      n_err++;
      $display("FAIL dirty_tag3 wb: got a0=%h d0=%h d1=%h want a0=00003230 d0=%h d1=0badf00d",
               (obs_q.size() > 0) ? obs_q[0].a : 32'hx, (obs_q.size() > 0) ? obs_q[0].d : 32'hx,
               (obs_q.size() > 1) ? obs_q[1].d : 32'hx, mem_word(32'h0000_3230));
    end
  endtask

  task automatic test_store_miss();
    logic [31:0] a_tab [2] = '{32'h0000_9234, 32'h0000_7234};
    logic        w_tab [2] = '{1'b1, 1'b0};
    for (int s = 0; s < 2; s++) begin
      predict(w_tab[s], a_tab[s], 32'h1234_5678, 1);
      run_req(w_tab[s], a_tab[s], 32'h1234_5678, 1);
      n_vec++; if (got_lat != exp_lat) begin n_err++; $display("FAIL store_miss%0d latency: got %0d want %0d", s, got_lat, exp_lat); end
      n_vec++; if (got_ctrl !== exp_ctrl) begin n_err++; $display("FAIL store_miss%0d done_ctrl: got %b want %b", s, got_ctrl, exp_ctrl); end
      n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL store_miss%0d beats: got %0d want %0d", s, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_vec++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL store_miss%0d beat%0d: got %h want %h", s, i, obs_q[i], exp_q[i]);
        end
      end
      if (exp_wa) begin
        n_vec++; if (any_ctrl) begin n_err++; $display("FAIL write_around control: got nonzero want 000000"); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_tab [4] = '{32'h0000_7238, 32'h0000_723C, 32'h0000_4450, 32'h0000_4454};
    logic        w_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int s = 0; s < 4; s++) begin
      predict(w_tab[s], a_tab[s], 32'hCAFE_0000 + 32'(s), 0);
      run_req(w_tab[s], a_tab[s], 32'hCAFE_0000 + 32'(s), 0);
      n_vec++; if (got_lat != exp_lat) begin n_err++; $display("FAIL b2b%0d latency: got %0d want %0d", s, got_lat, exp_lat); end
      n_vec++; if (got_ctrl !== exp_ctrl) begin n_err++; $display("FAIL b2b%0d done_ctrl: got %b want %b", s, got_ctrl, exp_ctrl); end
      n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b%0d beats: got %0d want %0d", s, obs_q.size(), exp_q.size()); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] wd;
    logic        wr;
    int          lat;
    for (int r = 0; r < 60; r++) begin
      a   = {12'h0, 8'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0) ? 8'h23 : 8'h45,
             2'($urandom_range(0, 3)), 2'b00};
      wr  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      lat = $urandom_range(0, 2);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      predict(wr, a, wd, lat);
      run_req(wr, a, wd, lat);
      n_vec++; if (got_lat != exp_lat) begin n_err++; $display("FAIL rand%0d latency: got %0d want %0d", r, got_lat, exp_lat); end
      n_vec++; if (got_ctrl !== exp_ctrl) begin n_err++; $display("FAIL rand%0d done_ctrl: got %b want %b", r, got_ctrl, exp_ctrl); end
      n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand%0d beats: got %0d want %0d", r, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_vec++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL rand%0d beat%0d: got %h want %h", r, i, obs_q[i], exp_q[i]);
        end
      end
      if (exp_wa) begin
        n_vec++; if (any_ctrl) begin n_err++; $display("FAIL rand%0d write_around control: got nonzero want 000000", r); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clean_miss();
    test_load_hit();
    test_store_hit();
    test_dirty_miss();
    test_store_miss();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Sequencing controller for one cache set datapath. It accepts single-word load/store requests from the processor and checks hit/dirty status from the set. It generates the set's 6-bit control vector every cycle, runs a word-serial write-back of the dirty victim on a miss, then refills the line from memory. It sits between the processor port, the set datapath and the memory bus.

## Interface
- TAG_WIDTH, `CACHE_T: tag bits of the address.
- OFFSET_WIDTH, `CACHE_B: byte-offset bits per line; words per line W = 2^(OFFSET_WIDTH-2).
- INDEX_WIDTH, 32-TAG_WIDTH-OFFSET_WIDTH: set-index bits.
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- req_valid_i  input  1  processor request; held, with addr_i and req_write_i stable, until done_o.
- req_write_i  input  1  1 = store, 0 = load.
- addr_i  input  32  request address.
- done_o  output  1  one-cycle completion pulse; load data is valid from the set in this cycle.
- hit_i  input  1  set hit for addr_i.
- dirty_i  input  1  the victim line is dirty.
- tag_dirty_line_i  input  TAG_WIDTH  tag of the dirty victim.
- wb_data_i  input  32  victim word at mem_addr_o offset; combinational from the datapath.
- control_o  output  6  {write_en, update_en, set_valid, set_dirty, strategy_en, offset_sel} to the set.
- mem_addr_o  output  32  memory word address; also drives the set's memory-address input.
- mem_req_o  output  1  memory request.
- mem_we_o  output  1  1 = memory write.
- mem_write_data_o  output  32  memory write data.
- mem_ack_i  input  1  memory completes the current word this cycle.

## Operation
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE, WRITE_AROUND.
- IDLE: control_o = 0 and mem_req_o = 0. On req_valid_i, go to COMPARE.
- COMPARE, hit, load: strategy_en=1, offset_sel=1, done_o=1, then IDLE.
- COMPARE, hit, store: write_en=1, update_en=1, set_valid=1, set_dirty=1, strategy_en=1, offset_sel=1, done_o=1, then IDLE.
- COMPARE, miss, dirty_i=1: go to WRITEBACK. Latch victim tag; word counter = 0.
- COMPARE, miss, dirty_i=0: go to ALLOCATE; word counter = 0.
- WRITEBACK: mem_req_o=1, mem_we_o=1.
  - mem_addr_o = {victim tag, addr_i index, cnt, 2'b00}; mem_write_data_o = wb_data_i.
  - Each mem_ack_i increments cnt. An ack with cnt = W-1 goes to ALLOCATE with cnt = 0.
- ALLOCATE: mem_req_o=1, mem_we_o=0, offset_sel=0, mem_addr_o = {addr_i tag, index, cnt, 2'b00}.
  - On ack: write_en=1 (this writes mem data into the set).
  - On the ack with cnt = W-1, also assert update_en=1, set_valid=1, set_dirty=0, then return to COMPARE. The request now hits.
  - strategy_en=0 throughout ALLOCATE.
- Counter width is OFFSET_WIDTH-2 and wraps to 0 after W-1.
- Victim tag is latched only in COMPARE. It is stable through WRITEBACK.
- Reset in any state: IDLE, cnt=0, all outputs 0. An in-flight memory word is abandoned; the line stays not-valid-updated.
- req_valid_i dropping mid-miss is illegal; behaviour is undefined and not checked.

## Timing
- Reset values: done_o=0, control_o=6'b0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_write_data_o=0.
- Hit latency: done_o is asserted 1 cycle after the request is first seen in IDLE (the COMPARE cycle).
- Clean-miss latency: 1 + W·(ack latency) + 1 cycles.
- Dirty-miss latency: adds W acked write beats.
- mem_req_o stays high across beats. Address and data change only in the cycle after an ack.
- mem_ack_i is ignored while mem_req_o=0.
- mem_ack_i asserted in the same cycle as the request is legal; that gives 1 word per cycle.
- A back-to-back request is accepted in the cycle after done_o.

## Configuration
- CACHE_WRITE_ALLOCATE_EN defined: a store miss follows the load-miss path (write-back if dirty, then ALLOCATE, then COMPARE hit-store).
- Not defined: a store miss goes to WRITE_AROUND.
  - One memory write: mem_addr_o = {addr_i[31:2], 2'b00}, data = write data from the processor word. This needs an added port write_data_i [31:0], present only when the macro is undefined.
  - On ack: done_o=1, then IDLE. control_o = 0, so the set is unchanged.
- Load misses are identical in both builds.

## Test plan
- Reset held 3 cycles mid-ALLOCATE (cnt=2) → all outputs 0 next cycle; state IDLE; next request starts at COMPARE.
- Load hit at 0x0000_1234 → done_o in cycle 2 with control_o=6'b000011; no mem_req_o.
- Clean load miss, W=4, ack every cycle → 4 read beats at offsets 0,4,8,C.
  - Last beat control_o=6'b111000; hit COMPARE; done_o on cycle 7.
- Dirty miss with victim tag 0x3, W=4, ack after 2 cycles → 4 write beats to {0x3, index, cnt} with wb_data_i, then 4 read beats, then done_o.
- Store hit → control_o=6'b111111 for one cycle with done_o.
- Store miss: with CACHE_WRITE_ALLOCATE_EN → refill then dirty hit-store; without it → a single mem write, done_o, control_o stays 0.
